// File: rtl/m_dbus_arb.sv
// Data-bus arbiter between the LSU and the page-table walker: round-robin grant,
// registered bus request held until ack or timeout, flush-aware LSU completion.
module m_dbus_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_ld_req,
  input  logic        lsu_st_req,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_byte_enable,
  input  logic        lsu_flush,
  input  logic        ptw_req,
  input  logic [31:0] ptw_addr,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        lsu_ack,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        ptw_ack,
  output logic [31:0] ptw_rdata,
  output logic        ptw_err,
  output logic [31:0] dbus_addr,
  output logic        dbus_ld_req,
  output logic        dbus_st_req,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_byte_enable,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, LSU_XFER, PTW_XFER} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_ptw_q, last_ptw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              killed_q, killed_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              ld_q, ld_d;
  logic              st_q, st_d;

  logic lsu_valid, grant_lsu, grant_ptw, timeout_hit, lsu_drop;

  always_comb begin
    lsu_valid   = (lsu_ld_req | lsu_st_req) & ~lsu_flush;
    grant_lsu   = lsu_valid & (~ptw_req | last_ptw_q);
    grant_ptw   = ptw_req & (~lsu_valid | ~last_ptw_q);
    timeout_hit = (TIMEOUT != 32'd0) && (state_q != IDLE) && !dbus_ack && (cnt_q == TMO_LAST);
    lsu_drop    = killed_q | lsu_flush;

    // A synchronous reset landing mid-transfer abandons it silently.
    lsu_ack   = !rst && (state_q == LSU_XFER) && dbus_ack && !lsu_drop;
    lsu_err   = !rst && (state_q == LSU_XFER) && timeout_hit && !lsu_drop;
    ptw_ack   = !rst && (state_q == PTW_XFER) && dbus_ack;
    ptw_err   = !rst && (state_q == PTW_XFER) && timeout_hit;
    lsu_rdata = lsu_ack ? dbus_rdata : '0;
    ptw_rdata = ptw_ack ? dbus_rdata : '0;
  end

  always_comb begin
    state_d    = state_q;
    last_ptw_d = last_ptw_q;
    cnt_d      = cnt_q;
    killed_d   = killed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ld_d       = ld_q;
    st_d       = st_q;
    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          state_d    = LSU_XFER;
          last_ptw_d = 1'b0;
          addr_d     = lsu_addr;
          wdata_d    = lsu_wdata;
          be_d       = lsu_byte_enable;
          st_d       = lsu_st_req;
          ld_d       = lsu_ld_req & ~lsu_st_req;
          cnt_d      = '0;
          killed_d   = 1'b0;
        end else if (grant_ptw) begin
          state_d    = PTW_XFER;
          last_ptw_d = 1'b1;
          addr_d     = ptw_addr;
          wdata_d    = '0;
          be_d       = '1;
          st_d       = 1'b0;
          ld_d       = 1'b1;
          cnt_d      = '0;
          killed_d   = 1'b0;
        end
      end
      default: begin
        if (state_q == LSU_XFER && lsu_flush) killed_d = 1'b1;
        if (dbus_ack || timeout_hit) begin
          state_d = IDLE;
          ld_d    = 1'b0;
          st_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_ptw_q <= 1'b1;
      cnt_q      <= '0;
      killed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptw_q <= last_ptw_d;
      cnt_q      <= cnt_d;
      killed_q   <= killed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
    end
  end

  assign dbus_addr        = addr_q;
  assign dbus_wdata       = wdata_q;
  assign dbus_byte_enable = be_q;
  assign dbus_ld_req      = ld_q;
  assign dbus_st_req      = st_q;
  assign arb_busy         = (state_q != IDLE);

endmodule
